// File: rtl/fifo_sched_pkg.sv
// Shared types and constants for the FIFO write/read scheduler.
// Holds the FSM state enum, default geometry and the level-width helper.
package fifo_sched_pkg;

    typedef enum logic {
        S_RUN,
        S_FLUSH
    } state_t;

    localparam int DEPTH_DEF = 8;
    localparam int DW_DEF    = 32;
    localparam int STAT_W    = 16;

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_rd_scheduler_if.sv
// Producer/consumer handshake bundle for the FIFO scheduler.
// The master side drives requests; the scheduler sits on the slave side.
interface fifo_wr_rd_scheduler_if #(
    parameter int NREQ = 4,
    parameter int DW   = 32
);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               rd_req;
    logic               rd_ack;

    modport master (
        output req_valid,
        output req_data,
        output rd_req,
        input  req_ready,
        input  rd_ack
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  rd_req,
        output req_ready,
        output rd_ack
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    function automatic int wrap(input int a);
        return (a >= NREQ) ? a - NREQ : a;
    endfunction

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[wrap(int'(ptr) + i)]) begin
                any                       = 1'b1;
                idx                       = IW'(wrap(int'(ptr) + i));
                grant[wrap(int'(ptr) + i)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_rd_scheduler.sv
// Round-robin write / read arbiter in front of the 8x32 FIFO.
// Optional per-port grant and conflict counters under SCHED_STATS_EN.
import fifo_sched_pkg::*;

module fifo_wr_rd_scheduler #(
    parameter int NREQ  = 4,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        flush,
    fifo_wr_rd_scheduler_if.slave       bus,
    output logic                        fifo_en,
    output logic                        fifo_rst,
    output logic                        fifo_wr,
    output logic                        fifo_rd,
    output logic [DW-1:0]               fifo_din,
    output logic [$clog2(NREQ)-1:0]     grant_id,
    output logic [lvl_w(DEPTH)-1:0]     level,
    output logic                        sched_full,
    output logic                        sched_empty
`ifdef SCHED_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0]      stat_grants,
    output logic [STAT_W-1:0]           stat_conflicts
`endif
);

    localparam int IW = $clog2(NREQ);
    localparam int LW = lvl_w(DEPTH);

    state_t          state;
    state_t          state_n;
    logic [LW-1:0]   level_q;
    logic [IW-1:0]   rr_ptr;
    logic            pri_rd;

    logic [NREQ-1:0] pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    logic            active;
    logic            wr_ok;
    logic            rd_ok;
    logic            conflict;
    logic            do_wr;
    logic            do_rd;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (pick_oh),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // A flush request blocks transfers in the very cycle it is seen.
    assign active   = !Rst && (state == S_RUN) && !flush;
    assign wr_ok    = pick_any && (level_q < LW'(DEPTH));
    assign rd_ok    = bus.rd_req && (level_q != '0);
    assign conflict = active && wr_ok && rd_ok;
    assign do_wr    = active && wr_ok && !(rd_ok && pri_rd);
    assign do_rd    = active && rd_ok && !(wr_ok && !pri_rd);

    always_comb begin
        state_n       = state;
        fifo_en       = 1'b1;
        fifo_rst      = Rst || (state == S_FLUSH);
        fifo_wr       = 1'b0;
        fifo_rd       = 1'b0;
        fifo_din      = '0;
        grant_id      = '0;
        bus.req_ready = '0;
        bus.rd_ack    = 1'b0;
        unique case (state)
            S_RUN:   if (flush) state_n = S_FLUSH;
            S_FLUSH: if (!flush) state_n = S_RUN;
            default: state_n = S_FLUSH;
        endcase
        unique case (1'b1)
            do_wr: begin
                fifo_wr       = 1'b1;
                fifo_din      = bus.req_data[pick_idx*DW +: DW];
                grant_id      = pick_idx;
                bus.req_ready = pick_oh;
            end
            do_rd: begin
                fifo_rd    = 1'b1;
                bus.rd_ack = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= S_FLUSH;
            level_q <= '0;
            rr_ptr  <= '0;
            pri_rd  <= 1'b0;
        end else begin
            state <= state_n;
            if ((state == S_FLUSH) || flush)
                level_q <= '0;
            else if (do_wr)
                level_q <= level_q + LW'(1);
            else if (do_rd)
                level_q <= level_q - LW'(1);
            if (do_wr)
                rr_ptr <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
            if (conflict)
                pri_rd <= ~pri_rd;
        end
    end

    assign level       = (Rst || (state == S_FLUSH)) ? '0 : level_q;
    assign sched_full  = (level == LW'(DEPTH));
    assign sched_empty = (level == '0);

`ifdef SCHED_STATS_EN
    logic [STAT_W-1:0] grants_q [NREQ];
    logic [STAT_W-1:0] conf_q;
    logic              stat_clr;

    assign stat_clr = Rst || (state == S_FLUSH);

    for (genvar i = 0; i < NREQ; i++) begin : g_stat
        always_ff @(posedge Clk) begin
            if (stat_clr)
                grants_q[i] <= '0;
            else if (bus.req_ready[i] && (grants_q[i] != '1))
                grants_q[i] <= grants_q[i] + STAT_W'(1);
        end
        assign stat_grants[i*STAT_W +: STAT_W] = grants_q[i];
    end

    always_ff @(posedge Clk) begin
        if (stat_clr)
            conf_q <= '0;
        else if (conflict && (conf_q != '1))
            conf_q <= conf_q + STAT_W'(1);
    end

    assign stat_conflicts = conf_q;
`endif

endmodule

// File: doc/fifo_wr_rd_scheduler.md
Name: fifo_wr_rd_scheduler

Overview:
Front-end controller for the team's 8-deep x 32-bit synchronous FIFO. It round-robins NREQ producer ports onto the FIFO's single write port and arbitrates that write against consumer read requests. The FIFO services only one operation per cycle, so the block never issues both in the same cycle. It keeps its own authoritative occupancy count and drives the FIFO's EN/Rst/WR/RD/dataIn pins; the FIFO's FULL/EMPTY outputs are not used.

Parameters:
NREQ, 4, number of producer ports (2..8)
DW, 32, data width
DEPTH, 8, FIFO capacity in entries

Ports:
Clk  in  1  clock; all logic on posedge
Rst  in  1  reset; synchronous, active-high
flush  in  1  request to empty the FIFO
req_valid  in  NREQ  producer i has a word
req_data  in  NREQ*DW  producer words; slice i = bits [i*DW +: DW]
req_ready  out  NREQ  one-hot grant; a transfer occurs when valid&ready on a Clk edge
rd_req  in  1  consumer wants one word
rd_ack  out  1  read issued this cycle; FIFO dataOut is valid from the next cycle
fifo_en  out  1  FIFO EN
fifo_rst  out  1  FIFO Rst
fifo_wr  out  1  FIFO WR
fifo_rd  out  1  FIFO RD
fifo_din  out  DW  FIFO dataIn
grant_id  out  $clog2(NREQ)  index of the granted port; valid when fifo_wr=1
level  out  $clog2(DEPTH+1)  current occupancy
sched_full  out  1  level==DEPTH
sched_empty  out  1  level==0

Behaviour:
- FSM states: RUN, FLUSH.
  - Rst=1 -> state<=FLUSH, level<=0, rr_ptr<=0, pri_rd<=0.
  - FLUSH -> RUN after one cycle, unless flush=1, which holds FLUSH.
  - RUN with flush=1 -> FLUSH. No transfer occurs in a cycle where flush=1.
- During Rst, and in FLUSH: fifo_rst=1 and fifo_en=1, so the FIFO pointers clear. All of req_ready, fifo_wr, fifo_rd and rd_ack are 0; fifo_din=0; grant_id=0; level reads 0.
- In RUN: fifo_en=1, fifo_rst=0.
- Eligibility:
  - wr_ok = |req_valid && level<DEPTH
  - rd_ok = rd_req && level!=0
- Conflict rule (wr_ok and rd_ok both true): read wins if pri_rd=1, otherwise write wins. pri_rd toggles only on a conflict cycle. Non-conflicting cycles leave pri_rd unchanged.
- Write path:
  - The winner is the first valid port searching upward from rr_ptr, with modulo-NREQ wrap.
  - Outputs in the same cycle (combinational, zero latency): req_ready[g]=1, fifo_wr=1, fifo_din=req_data[g], grant_id=g.
  - Registered effects: rr_ptr<=(g+1)%NREQ, level<=level+1.
- Read path: fifo_rd=1 and rd_ack=1; level<=level-1. rr_ptr is unchanged.
- level never increments and decrements in the same cycle, and never leaves 0..DEPTH.
- At level==DEPTH: all req_ready=0, and reads still proceed. At level==0: rd_req is ignored and rd_ack=0.
- A producer whose valid drops before it is granted loses nothing; the port is simply skipped.
- sched_full and sched_empty are decoded combinationally from level.

Optional Feature:
Macro SCHED_STATS_EN.
- Defined: adds output stat_grants (NREQ*16), one saturating 16-bit grant counter per port. Each counter increments on that port's handshake and sticks at 16'hFFFF. Counters clear on Rst and in FLUSH. Also adds output stat_conflicts (16, saturating), incremented on every conflict cycle.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Package fifo_sched_pkg holds:
  - state enum {S_RUN, S_FLUSH}
  - DEPTH_DEF=8 and DW_DEF=32
  - a helper function for the level width
  - the stats counter width (16)
- Sub-module rr_pick: combinational round-robin picker. Inputs are a NREQ request vector and rr_ptr. Outputs are a one-hot grant, the index, and any.

Test Plan:
- Reset, then req_valid=4'b1111 held for 8 cycles, rd_req=0 -> grants in order 0,1,2,3,0,1,2,3; level reaches 8; sched_full=1; req_ready=0 on the 9th cycle.
- With level=8: rd_req=1 for 8 cycles -> rd_ack=1 on each; level steps 8->0; sched_empty=1; a 9th rd_req gives rd_ack=0.
- Conflict: level=3, req_valid=4'b0001 and rd_req=1 held for 4 cycles -> sequence write, read, write, read; level ends at 3; pri_rd toggles each cycle.
- Sparse round robin: rr_ptr=2, req_valid=4'b1001 -> grant 3, then 0, then 3; ports 1 and 2 never granted.
- Flush at level=5 while req_valid=4'b0100 -> no handshake that cycle; next cycle fifo_rst=1 and level=0; then RUN resumes with a grant to port 2.
- Rst asserted mid-stream at level=6 -> next cycle all strobes 0, fifo_rst=1, level=0, rr_ptr=0; the first grant after release goes to the lowest valid port.
